// File: rtl/flopoco_fcmp_pkg.sv
// ============================================================================
//  Module : flopoco_fcmp_pkg
//  Brief  : Types and predicate evaluation shared by the FloPoCo compare pipe.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package flopoco_fcmp_pkg;

  typedef enum logic [1:0] {
    EXC_ZERO   = 2'b00,
    EXC_NORMAL = 2'b01,
    EXC_INF    = 2'b10,
    EXC_NAN    = 2'b11
  } exc_t;

  typedef enum logic [2:0] {
    OP_LT  = 3'd0,
    OP_LE  = 3'd1,
    OP_EQ  = 3'd2,
    OP_NE  = 3'd3,
    OP_GT  = 3'd4,
    OP_GE  = 3'd5,
    OP_ORD = 3'd6,
    OP_UNO = 3'd7
  } fcmp_op_t;

  typedef struct packed {
    logic zero;
    logic normal;
    logic inf;
    logic nan;
    logic sign;
  } fcmp_dec_t;

  typedef struct packed {
    fcmp_dec_t x;
    fcmp_dec_t y;
    fcmp_op_t  op;
    logic      mag_lt;
    logic      mag_eq;
    logic      mag_gt;
  } fcmp_s0_t;

  typedef struct packed {
    logic result;
    logic unordered;
    logic sig;        // signaling predicate saw a NaN
  } fcmp_res_t;

  function automatic fcmp_res_t fcmp_eval(input fcmp_s0_t s);
    fcmp_res_t r;
    logic      unord;
    logic      eq;
    logic      lt;
    logic      gt;
    unord = s.x.nan | s.y.nan;
    eq = ~unord & ((s.x.zero & s.y.zero) |
                   (s.x.inf & s.y.inf & (s.x.sign == s.y.sign)) |
                   (s.x.normal & s.y.normal & (s.x.sign == s.y.sign) & s.mag_eq));
    lt = 1'b0;
    if (!unord) begin
      if (s.x.zero) begin
        lt = (s.y.normal | s.y.inf) & ~s.y.sign;
      end else if (s.x.normal) begin
        // Two negatives: the larger magnitude is the smaller value
        if (s.x.sign)
          lt = s.y.zero | ((s.y.normal | s.y.inf) & ~s.y.sign) |
               (s.y.normal & s.y.sign & s.mag_gt);
        else
          lt = (s.y.inf & ~s.y.sign) | (s.y.normal & ~s.y.sign & s.mag_lt);
      end else if (s.x.inf & s.x.sign) begin
        lt = ~(s.y.inf & s.y.sign);
      end
    end
    gt = ~unord & ~lt & ~eq;
    case (s.op)
      OP_LT:   r.result = lt;
      OP_LE:   r.result = lt | eq;
      OP_EQ:   r.result = eq;
      OP_NE:   r.result = ~eq;
      OP_GT:   r.result = gt;
      OP_GE:   r.result = gt | eq;
      OP_ORD:  r.result = ~unord;
      default: r.result = unord;
    endcase
    r.unordered = unord;
    r.sig = unord & ((s.op == OP_LT) | (s.op == OP_LE) | (s.op == OP_GT) | (s.op == OP_GE));
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/flopoco_fcmp_decode.sv
// ============================================================================
//  Module : flopoco_fcmp_decode
//  Brief  : Classifies both operands and compares their {exp,frac} magnitudes.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flopoco_fcmp_decode
  import flopoco_fcmp_pkg::*;
#(
  parameter int WE = 8,
  parameter int WF = 8
) (
  input  logic [WE+WF+2:0] i_x,
  input  logic [WE+WF+2:0] i_y,
  output fcmp_dec_t        o_dx,
  output fcmp_dec_t        o_dy,
  output logic             o_mag_lt,
  output logic             o_mag_eq,
  output logic             o_mag_gt
);

  exc_t              w_ex;
  exc_t              w_ey;
  logic [WE+WF-1:0]  w_mx;
  logic [WE+WF-1:0]  w_my;

  assign w_ex = exc_t'(i_x[WE+WF+2 -: 2]);
  assign w_ey = exc_t'(i_y[WE+WF+2 -: 2]);
  assign w_mx = i_x[WE+WF-1:0];
  assign w_my = i_y[WE+WF-1:0];

  always_comb begin
    o_dx.zero   = (w_ex == EXC_ZERO);
    o_dx.normal = (w_ex == EXC_NORMAL);
    o_dx.inf    = (w_ex == EXC_INF);
    o_dx.nan    = (w_ex == EXC_NAN);
    o_dx.sign   = i_x[WE+WF];
    o_dy.zero   = (w_ey == EXC_ZERO);
    o_dy.normal = (w_ey == EXC_NORMAL);
    o_dy.inf    = (w_ey == EXC_INF);
    o_dy.nan    = (w_ey == EXC_NAN);
    o_dy.sign   = i_y[WE+WF];
  end

  assign o_mag_lt = (w_mx < w_my);
  assign o_mag_eq = (w_mx == w_my);
  assign o_mag_gt = (w_mx > w_my);

endmodule

`default_nettype wire

// File: rtl/flopoco_fcmp_pipe.sv
// ============================================================================
//  Module : flopoco_fcmp_pipe
//  Brief  : Valid/ready pipelined FloPoCo float comparator, eight predicates.
//           Define FCMP_SIGNALING_EN for the sticky invalid flag.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flopoco_fcmp_pipe
  import flopoco_fcmp_pkg::*;
#(
  parameter int WE     = 8,
  parameter int WF     = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WE+WF+2:0] X,
  input  logic [WE+WF+2:0] Y,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             unordered
`ifdef FCMP_SIGNALING_EN
  ,
  output logic             invalid,
  input  logic             inv_clr
`endif
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("flopoco_fcmp_pipe: STAGES must be in 1..4");
  end

  fcmp_dec_t          w_dx;
  fcmp_dec_t          w_dy;
  logic               w_mag_lt;
  logic               w_mag_eq;
  logic               w_mag_gt;
  fcmp_s0_t           w_s0;
  logic [STAGES-1:0]  r_v;
  logic [STAGES-1:0]  w_ld;
  fcmp_res_t          r_res;

  flopoco_fcmp_decode #(.WE(WE), .WF(WF)) u_decode (
    .i_x      (X),
    .i_y      (Y),
    .o_dx     (w_dx),
    .o_dy     (w_dy),
    .o_mag_lt (w_mag_lt),
    .o_mag_eq (w_mag_eq),
    .o_mag_gt (w_mag_gt)
  );

  always_comb begin
    w_s0.x      = w_dx;
    w_s0.y      = w_dy;
    w_s0.op     = fcmp_op_t'(op);
    w_s0.mag_lt = w_mag_lt;
    w_s0.mag_eq = w_mag_eq;
    w_s0.mag_gt = w_mag_gt;
  end

  // A stage loads unless it and every stage after it are full and the output is stalled
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic w_src;
    if (gi == 0) begin : g_first
      assign w_src = in_valid;
    end else begin : g_next
      assign w_src = r_v[gi-1];
    end
    assign w_ld[gi] = out_ready | ~(&r_v[STAGES-1:gi]);
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_v[gi] <= 1'b0;
      else if (w_ld[gi])
        r_v[gi] <= w_src;
    end
  end

  if (STAGES == 1) begin : g_single
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_res <= '0;
      else if (w_ld[0])
        r_res <= fcmp_eval(w_s0);
    end
  end else begin : g_multi
    fcmp_s0_t r_pay [STAGES-1];
    always_ff @(posedge clk) begin
      if (w_ld[0])
        r_pay[0] <= w_s0;
      for (int i = 1; i < STAGES-1; i++)
        if (w_ld[i])
          r_pay[i] <= r_pay[i-1];
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_res <= '0;
      else if (w_ld[STAGES-1])
        r_res <= fcmp_eval(r_pay[STAGES-2]);
    end
  end

  assign in_ready  = w_ld[0];
  assign out_valid = r_v[STAGES-1];
  assign result    = r_res.result;
  assign unordered = r_res.unordered;

`ifdef FCMP_SIGNALING_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      invalid <= 1'b0;
    else if (out_valid & out_ready & r_res.sig)
      invalid <= 1'b1;
    else if (inv_clr)
      invalid <= 1'b0;
  end
`else
  logic w_unused_sig;
  assign w_unused_sig = r_res.sig;
`endif

endmodule

`default_nettype wire

// File: tb/tb_flopoco_fcmp_pipe.sv
// ============================================================================
//  Module : tb_flopoco_fcmp_pipe
//  Brief  : Directed-vector bench for flopoco_fcmp_pipe (STAGES 2, plus 1 and 4).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_flopoco_fcmp_pipe;
  import flopoco_fcmp_pkg::*;

  localparam int W = 19;
  localparam logic [W-1:0] c_p1 = 19'h27F00, c_p2 = 19'h28000, c_m1 = 19'h37F00,
                           c_m2 = 19'h38000, c_pz = 19'h00000, c_mz = 19'h10000,
                           c_pi = 19'h40000, c_mi = 19'h50000, c_nan = 19'h60000;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [2:0]   op;
    logic         res;
    logic         unord;
  } vec_t;

  typedef struct {
    logic res;
    logic unord;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, inv_clr = 1'b0;
  logic [W-1:0] X = '0, Y = '0;
  logic [2:0] op = '0;
  wire in_ready, out_valid, result, unordered;
  wire in_ready1, out_valid1, result1, unord1;
  wire in_ready4, out_valid4, result4, unord4;
`ifdef FCMP_SIGNALING_EN
  wire invalid, invalid1, invalid4;
`endif

  flopoco_fcmp_pipe #(.WE(8), .WF(8), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .unordered(unordered)
`ifdef FCMP_SIGNALING_EN
    , .invalid(invalid), .inv_clr(inv_clr)
`endif
  );

  flopoco_fcmp_pipe #(.WE(8), .WF(8), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .X(X), .Y(Y), .op(op),
    .out_valid(out_valid1), .out_ready(1'b1), .result(result1), .unordered(unord1)
`ifdef FCMP_SIGNALING_EN
    , .invalid(invalid1), .inv_clr(inv_clr)
`endif
  );

  flopoco_fcmp_pipe #(.WE(8), .WF(8), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .X(X), .Y(Y), .op(op),
    .out_valid(out_valid4), .out_ready(1'b1), .result(result4), .unordered(unord4)
`ifdef FCMP_SIGNALING_EN
    , .invalid(invalid4), .inv_clr(inv_clr)
`endif
  );

  always #5 clk = ~clk;

  int   n_tests = 0, n_fail = 0, cyc = 0, hand_cnt = 0;
  exp_t q[$];
  logic cur_res = 1'b0, cur_unord = 1'b0;
  bit   accepted = 1'b0, saw_not_ready = 1'b0, stall_prev = 1'b0;
  logic stall_res = 1'b0;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // One clock: sample/score at the falling edge, then step past the rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!in_ready) saw_not_ready = 1'b1;
    if (stall_prev) begin
      check("stall_valid", out_valid, 1);
      check("stall_result", result, stall_res);
    end
    if (out_valid && out_ready) begin
      hand_cnt++;
      if (q.size() == 0) fail_now("spurious_output");
      else begin
        e = q.pop_front();
        check("sb_result", result, e.res);
        check("sb_unord", unordered, e.unord);
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_res  = result;
    accepted   = in_valid && in_ready;
    if (accepted) q.push_back('{cur_res, cur_unord});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load(input vec_t v);
    X = v.x; Y = v.y; op = v.op; cur_res = v.res; cur_unord = v.unord; in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int n = 0;
    load(v);
    do begin tick(); n++; end while (!accepted && n < 20);
    if (!accepted) fail_now("send_timeout");
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 40) begin tick(); n++; end
    if (q.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    vecs[0]  = '{c_p1,  c_p2, OP_LT,  1'b1, 1'b0};
    vecs[1]  = '{c_p1,  c_p2, OP_GT,  1'b0, 1'b0};
    vecs[2]  = '{c_pz,  c_mz, OP_EQ,  1'b1, 1'b0};
    vecs[3]  = '{c_pz,  c_mz, OP_LT,  1'b0, 1'b0};
    vecs[4]  = '{c_pz,  c_mz, OP_GE,  1'b1, 1'b0};
    vecs[5]  = '{c_m1,  c_pi, OP_LT,  1'b1, 1'b0};
    vecs[6]  = '{c_mi,  c_mi, OP_EQ,  1'b1, 1'b0};
    vecs[7]  = '{c_mi,  c_mi, OP_LT,  1'b0, 1'b0};
    vecs[8]  = '{c_nan, c_p1, OP_LT,  1'b0, 1'b1};
    vecs[9]  = '{c_nan, c_p1, OP_NE,  1'b1, 1'b1};
    vecs[10] = '{c_nan, c_p1, OP_UNO, 1'b1, 1'b1};
    vecs[11] = '{c_nan, c_p1, OP_ORD, 1'b0, 1'b1};
    vecs[12] = '{c_m1,  c_m2, OP_GT,  1'b1, 1'b0};
    vecs[13] = '{c_pi,  c_mi, OP_NE,  1'b1, 1'b0};
    vecs[14] = '{c_p2,  c_p1, OP_LE,  1'b0, 1'b0};
    vecs[15] = '{c_p1,  c_p1, OP_LE,  1'b1, 1'b0};

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_unordered", unordered, 0);
`ifdef FCMP_SIGNALING_EN
    check("rst_invalid", invalid, 0);
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Back-to-back LT then GT, latency per depth
    load(vecs[0]); tick();
    check("s1_accept_lt", accepted, 1);
    check("s1_d2_not_yet", out_valid, 0);
    check("s1_d1_valid", out_valid1, 1);
    check("s1_d1_lt", result1, 1);
    load(vecs[1]); tick();
    check("s1_accept_gt", accepted, 1);
    in_valid = 1'b0;
    check("s1_d2_valid", out_valid, 1);
    check("s1_d2_lt", result, 1);
    check("s1_d1_gt", result1, 0);
    tick();
    check("s1_d2_gt_valid", out_valid, 1);
    check("s1_d2_gt", result, 0);
    check("s1_d1_empty", out_valid1, 0);
    check("s1_d4_not_yet", out_valid4, 0);
    tick();
    check("s1_d2_empty", out_valid, 0);
    check("s1_d4_valid", out_valid4, 1);
    check("s1_d4_lt", result4, 1);
    tick();
    check("s1_d4_gt_valid", out_valid4, 1);
    check("s1_d4_gt", result4, 0);
    tick();
    check("s1_d4_empty", out_valid4, 0);
    drain();

    // Full table streamed back to back
    for (int i = 0; i < 16; i++) send(vecs[i]);
    drain();

    // Back-pressure: out_ready low for cycles 3..5 of an 8-request burst
    begin
      int base, h0;
      base = cyc; h0 = hand_cnt; saw_not_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
        int n = 0;
        load(vecs[i]);
        do begin
          out_ready = !((cyc - base) >= 3 && (cyc - base) <= 5);
          tick(); n++;
        end while (!accepted && n < 20);
        if (!accepted) fail_now("s4_send_timeout");
      end
      out_ready = 1'b1;
      drain();
      check("s4_in_ready_fell", saw_not_ready, 1);
      check("s4_handoffs", hand_cnt - h0, 8);
    end

    // Asynchronous reset with two results in flight
    send(vecs[12]); send(vecs[13]);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1 check("s5_async_clear", out_valid, 0);
    check("s5_async_result", result, 0);
    q.delete(); stall_prev = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s5_no_stale", out_valid, 0);
    end
    send(vecs[12]);
    drain();

`ifdef FCMP_SIGNALING_EN
    begin
      vec_t v;
      v = '{c_nan, c_p1, OP_EQ, 1'b0, 1'b1};
      send(v); send(v); drain();
      check("s3_eq_quiet", invalid, 0);
      send(vecs[8]); drain();
      check("s3_lt_sets", invalid, 1);
      tick(); tick();
      check("s3_sticky", invalid, 1);
      inv_clr = 1'b1; tick(); inv_clr = 1'b0;
      check("s3_cleared", invalid, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
